// File: rtl/mesm6_uart_ctl.sv
// mesm6_uart_ctl -- bus-master sequencer for the mesm6_uart register port.
//
// After reset it configures the UART (CTRL <- 0, then CTRLSET <- enable),
// then loops polling CTRL. Depending on the status it clears a latched
// framing error, reads a received byte into a one-byte holding register,
// or writes the head of a 4-entry client TX FIFO to DATA. With no work it
// idles POLL_GAP cycles between polls.
//
// Ports
//   i_clk, i_reset          clock, asynchronous active-high reset
//   o_u_addr/o_u_read/o_u_write/o_u_wdata
//                           UART access; held stable until i_u_done
//   i_u_rdata, i_u_done     UART read data (valid with done), completion
//   i_tx_data/i_tx_valid/o_tx_ready   client TX byte stream into the FIFO
//   o_rx_data/o_rx_valid/i_rx_ready   received byte out to the client
//   o_inited                configuration sequence complete
//   o_ferr_cnt              framing errors cleared, saturating at 255
module mesm6_uart_ctl #(
  parameter int POLL_GAP  = 16,
  parameter int TXRDY_BIT = 0,
  parameter int RXAV_BIT  = 1,
  parameter int FERR_BIT  = 2,
  parameter int EN_BIT    = 9
) (
  input  logic        i_clk,
  input  logic        i_reset,
  output logic [14:0] o_u_addr,
  output logic        o_u_read,
  output logic        o_u_write,
  output logic [47:0] o_u_wdata,
  input  logic [47:0] i_u_rdata,
  input  logic        i_u_done,
  input  logic [7:0]  i_tx_data,
  input  logic        i_tx_valid,
  output logic        o_tx_ready,
  output logic [7:0]  o_rx_data,
  output logic        o_rx_valid,
  input  logic        i_rx_ready,
  output logic        o_inited,
  output logic [7:0]  o_ferr_cnt
);

  localparam logic [14:0] ADDR_CTRL    = 15'd7;
  localparam logic [14:0] ADDR_CTRLSET = 15'd6;
  localparam logic [14:0] ADDR_CTRLCLR = 15'd5;
  localparam logic [14:0] ADDR_DATA    = 15'd0;
  localparam logic [47:0] EN_MASK      = 48'd1 << EN_BIT;
  localparam logic [47:0] FERR_MASK    = 48'd1 << FERR_BIT;
  localparam int          GAP_W        = (POLL_GAP > 1) ? $clog2(POLL_GAP + 1) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(POLL_GAP - 1);

  typedef enum logic [2:0] {
    S_INIT_CLR, S_INIT_SET, S_POLL, S_RX_RD, S_TX_WR, S_FERR_CLR, S_WAIT
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [7:0]       r_fifo [0:3];
  logic [1:0]       r_wr_ptr, r_rd_ptr;
  logic [2:0]       r_count;
  logic             r_txrdy_last;
  logic [GAP_W-1:0] r_gap_cnt;

  logic        w_busy, w_fin, w_start;
  logic        w_acc_en, w_acc_wr;
  logic [14:0] w_acc_addr;
  logic [47:0] w_acc_wdata;
  logic        w_push, w_pop, w_fifo_ne;
  logic        w_unused;

  // Only the status bits and the low data byte of the read bus matter.
  assign w_unused = ^i_u_rdata;

  assign w_busy     = o_u_read | o_u_write;
  assign w_fin      = w_busy & i_u_done;
  assign w_fifo_ne  = (r_count != 3'd0);
  assign o_tx_ready = (r_count != 3'd4);
  assign w_push     = i_tx_valid & o_tx_ready;
  assign w_pop      = w_fin & (r_state == S_TX_WR);
  // An access starts only when no strobe is up; since completion drops the
  // strobe and changes state together, the cycle after done is always idle.
  assign w_start    = w_acc_en & ~w_busy;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_state <= S_INIT_CLR;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_acc_en    = 1'b0;
    w_acc_wr    = 1'b0;
    w_acc_addr  = ADDR_DATA;
    w_acc_wdata = 48'd0;
    case (r_state)
      S_INIT_CLR: begin
        w_acc_en   = 1'b1;
        w_acc_wr   = 1'b1;
        w_acc_addr = ADDR_CTRL;
        if (w_fin) w_state_nxt = S_INIT_SET;
      end
      S_INIT_SET: begin
        w_acc_en    = 1'b1;
        w_acc_wr    = 1'b1;
        w_acc_addr  = ADDR_CTRLSET;
        w_acc_wdata = EN_MASK;
        if (w_fin) w_state_nxt = S_POLL;
      end
      S_POLL: begin
        w_acc_en   = 1'b1;
        w_acc_addr = ADDR_CTRL;
        if (w_fin) begin
          if (i_u_rdata[FERR_BIT])                         w_state_nxt = S_FERR_CLR;
          else if (i_u_rdata[RXAV_BIT] && !o_rx_valid)     w_state_nxt = S_RX_RD;
          else if (i_u_rdata[TXRDY_BIT] && w_fifo_ne)      w_state_nxt = S_TX_WR;
          else                                             w_state_nxt = S_WAIT;
        end
      end
      S_RX_RD: begin
        w_acc_en   = 1'b1;
        w_acc_addr = ADDR_DATA;
        if (w_fin) w_state_nxt = S_POLL;
      end
      S_TX_WR: begin
        w_acc_en    = 1'b1;
        w_acc_wr    = 1'b1;
        w_acc_addr  = ADDR_DATA;
        w_acc_wdata = {40'd0, r_fifo[r_rd_ptr]};
        if (w_fin) w_state_nxt = S_POLL;
      end
      S_FERR_CLR: begin
        w_acc_en    = 1'b1;
        w_acc_wr    = 1'b1;
        w_acc_addr  = ADDR_CTRLCLR;
        w_acc_wdata = FERR_MASK;
        if (w_fin) w_state_nxt = S_POLL;
      end
      S_WAIT: begin
        // Fresh client data with a transmitter known to be ready skips the gap.
        if (r_gap_cnt == GAP_LAST || (w_fifo_ne && r_txrdy_last))
          w_state_nxt = S_POLL;
      end
      default: w_state_nxt = S_INIT_CLR;
    endcase
  end

  // Bus master registers, status latch, counters.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_u_read     <= 1'b0;
      o_u_write    <= 1'b0;
      o_u_addr     <= 15'd0;
      o_u_wdata    <= 48'd0;
      o_rx_data    <= 8'd0;
      o_rx_valid   <= 1'b0;
      o_inited     <= 1'b0;
      o_ferr_cnt   <= 8'd0;
      r_txrdy_last <= 1'b0;
      r_gap_cnt    <= '0;
    end else begin
      if (w_start) begin
        o_u_read  <= ~w_acc_wr;
        o_u_write <= w_acc_wr;
        o_u_addr  <= w_acc_addr;
        o_u_wdata <= w_acc_wdata;
      end else if (w_fin) begin
        o_u_read  <= 1'b0;
        o_u_write <= 1'b0;
      end

      if (w_fin && r_state == S_RX_RD) begin
        o_rx_data  <= i_u_rdata[7:0];
        o_rx_valid <= 1'b1;
      end else if (o_rx_valid && i_rx_ready) begin
        o_rx_valid <= 1'b0;
      end

      if (w_fin && r_state == S_INIT_SET) o_inited <= 1'b1;

      if (w_fin && r_state == S_FERR_CLR && o_ferr_cnt != 8'hFF)
        o_ferr_cnt <= o_ferr_cnt + 8'd1;

      if (w_fin && r_state == S_POLL) r_txrdy_last <= i_u_rdata[TXRDY_BIT];

      if (r_state == S_WAIT && w_state_nxt == S_WAIT) r_gap_cnt <= r_gap_cnt + 1'b1;
      else                                           r_gap_cnt <= '0;
    end
  end

  // TX FIFO pointers and occupancy.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_wr_ptr <= 2'd0;
      r_rd_ptr <= 2'd0;
      r_count  <= 3'd0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 2'd1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 2'd1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 3'd1;
        2'b01:   r_count <= r_count - 3'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // FIFO storage needs no reset; pointers define what is valid.
  always_ff @(posedge i_clk) begin
    if (w_push) r_fifo[r_wr_ptr] <= i_tx_data;
  end

endmodule

// File: tb/tb_mesm6_uart_ctl.sv
// Testbench for mesm6_uart_ctl: a UART register model with random access
// latency answers the controller, a client model pushes/consumes bytes, and
// a monitor checks every bus access and client output against queues filled
// by the reference model.
module tb_mesm6_uart_ctl;

  logic        clk = 1'b0;
  logic        reset;
  logic [14:0] o_u_addr;
  logic        o_u_read, o_u_write;
  logic [47:0] o_u_wdata;
  logic [47:0] i_u_rdata;
  logic        i_u_done;
  logic [7:0]  i_tx_data;
  logic        i_tx_valid;
  logic        o_tx_ready;
  logic [7:0]  o_rx_data;
  logic        o_rx_valid;
  logic        i_rx_ready;
  logic        o_inited;
  logic [7:0]  o_ferr_cnt;

  always #5 clk = ~clk;

  mesm6_uart_ctl dut (
    .i_clk(clk), .i_reset(reset),
    .o_u_addr(o_u_addr), .o_u_read(o_u_read), .o_u_write(o_u_write),
    .o_u_wdata(o_u_wdata), .i_u_rdata(i_u_rdata), .i_u_done(i_u_done),
    .i_tx_data(i_tx_data), .i_tx_valid(i_tx_valid), .o_tx_ready(o_tx_ready),
    .o_rx_data(o_rx_data), .o_rx_valid(o_rx_valid), .i_rx_ready(i_rx_ready),
    .o_inited(o_inited), .o_ferr_cnt(o_ferr_cnt)
  );

  typedef struct packed {
    logic        wr;
    logic [14:0] addr;
    logic [47:0] wdata;
  } acc_t;

  acc_t       exp_acc[$];     // expected bus accesses, in order
  logic [7:0] exp_rx[$];      // expected bytes presented to the client
  logic [7:0] model_fifo[$];  // bytes accepted but not yet written to DATA
  logic [7:0] rxq[$];         // bytes waiting inside the modelled UART
  bit         model_rxv, model_inited, uferr;
  int         model_ferr;
  bit         acc_active;
  int         lat, lat_cnt;

  int errors = 0;
  int checks = 0;

  // stimulus knobs (percent probabilities)
  int p_txv, p_rx, p_ferr, p_rxrdy, p_txrdy;
  logic [7:0] force_q[$];

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic acc_t mk(input bit wr, input int a, input logic [47:0] d);
    acc_t r;
    r.wr = wr; r.addr = 15'(a); r.wdata = d;
    return r;
  endfunction

  task automatic model_reset();
    exp_acc.delete(); exp_rx.delete(); model_fifo.delete(); rxq.delete();
    model_rxv = 0; model_inited = 0; uferr = 0; model_ferr = 0;
    acc_active = 0; lat = 0; lat_cnt = 0;
    exp_acc.push_back(mk(1, 7, 48'd0));
    exp_acc.push_back(mk(1, 6, 48'o1000));
    exp_acc.push_back(mk(0, 7, 48'd0));
  endtask

  // Called at each negedge: choose inputs for the coming edge and apply the
  // effects of that edge to the reference model.
  task automatic step();
    logic [47:0] rd;
    logic [7:0]  b, txd;
    bit strobe, done, txv, rxr, pre_rxv;
    int pre_cnt;
    strobe = o_u_read | o_u_write;
    done = 0;
    if (strobe) begin
      if (!acc_active) begin
        acc_active = 1; lat = int'($urandom_range(0, 5)); lat_cnt = 0;
      end else lat_cnt++;
      done = (lat_cnt >= lat);
    end else acc_active = 0;

    if (force_q.size() > 0) begin
      txv = 1; txd = force_q.pop_front();
    end else begin
      txv = ($urandom % 100) < p_txv; txd = 8'($urandom);
    end
    rxr = ($urandom % 100) < p_rxrdy;
    rd  = {16'($urandom), $urandom};

    pre_rxv = model_rxv;
    pre_cnt = model_fifo.size();
    if (pre_rxv && rxr) model_rxv = 0;

    if (done) begin
      acc_active = 0;
      if (o_u_read && o_u_addr == 15'd7) begin
        rd[0] = ($urandom % 100) < p_txrdy;
        rd[1] = rxq.size() > 0;
        rd[2] = uferr;
        if (rd[2])                     exp_acc.push_back(mk(1, 5, 48'o4));
        else if (rd[1] && !pre_rxv)    exp_acc.push_back(mk(0, 0, 48'd0));
        else if (rd[0] && pre_cnt > 0) exp_acc.push_back(mk(1, 0, {40'd0, model_fifo[0]}));
        exp_acc.push_back(mk(0, 7, 48'd0));
      end else if (o_u_read && o_u_addr == 15'd0) begin
        b = (rxq.size() > 0) ? rxq.pop_front() : 8'hFF;
        rd[7:0] = b;
        exp_rx.push_back(b);
        model_rxv = 1;
      end else if (o_u_write) begin
        if (o_u_addr == 15'd0 && model_fifo.size() > 0) void'(model_fifo.pop_front());
        if (o_u_addr == 15'd5 && o_u_wdata[2]) begin
          uferr = 0;
          if (model_ferr < 255) model_ferr++;
        end
        if (o_u_addr == 15'd6) model_inited = 1;
      end
    end

    if (txv && pre_cnt < 4) model_fifo.push_back(txd);
    if (($urandom % 100) < p_rx && rxq.size() < 3) rxq.push_back(8'($urandom));
    if (($urandom % 100) < p_ferr) uferr = 1;

    i_u_done   = done;
    i_u_rdata  = rd;
    i_tx_valid = txv;
    i_tx_data  = txd;
    i_rx_ready = rxr;
  endtask

  task automatic run(input int n);
    repeat (n) begin
      @(negedge clk);
      if (!reset) step();
    end
  endtask

  task automatic idle_inputs();
    i_u_done = 0; i_u_rdata = 48'd0; i_tx_valid = 0; i_tx_data = 8'd0; i_rx_ready = 0;
  endtask

  // Monitor: compares DUT outputs against the model's queues after each edge.
  initial begin
    bit prd, pwr, prxv, fin;
    acc_t cap, e;
    prd = 0; pwr = 0; prxv = 0; cap = '0;
    forever begin
      @(posedge clk);
      #1;
      if (reset) begin
        check("reset_strobes", 80'({o_u_read, o_u_write}), 80'd0);
        check("reset_addr",    80'(o_u_addr), 80'd0);
        check("reset_wdata",   80'(o_u_wdata), 80'd0);
        check("reset_rx",      80'({o_rx_valid, o_rx_data}), 80'd0);
        check("reset_inited",  80'(o_inited), 80'd0);
        check("reset_ferr",    80'(o_ferr_cnt), 80'd0);
        check("reset_txready", 80'(o_tx_ready), 80'd1);
        prd = 0; pwr = 0; prxv = 0;
      end else begin
        fin = i_u_done && (prd || pwr);
        if (fin) begin
          check("strobe_drop", 80'({o_u_read, o_u_write}), 80'd0);
        end else if ((prd || pwr) && (o_u_read || o_u_write)) begin
          check("hold_stable", 80'({o_u_read, o_u_write, o_u_addr, o_u_wdata}),
                80'({prd, pwr, cap.addr, cap.wdata}));
        end else if (o_u_read || o_u_write) begin
          cap.wr = o_u_write; cap.addr = o_u_addr; cap.wdata = o_u_wdata;
          check("one_strobe", 80'(o_u_read & o_u_write), 80'd0);
          if (exp_acc.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_access: got wr=%0b addr=%0d expected none at %0t",
                     o_u_write, o_u_addr, $time);
          end else begin
            e = exp_acc.pop_front();
            check("acc_type", 80'(o_u_write), 80'(e.wr));
            check("acc_addr", 80'(o_u_addr), 80'(e.addr));
            if (e.wr) check("acc_wdata", 80'(o_u_wdata), 80'(e.wdata));
          end
        end
        check("tx_ready",  80'(o_tx_ready), 80'(model_fifo.size() != 4));
        check("rx_valid",  80'(o_rx_valid), 80'(model_rxv));
        check("inited",    80'(o_inited), 80'(model_inited));
        check("ferr_cnt",  80'(o_ferr_cnt), 80'(model_ferr));
        if (o_rx_valid && !prxv) begin
          if (exp_rx.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_rx: got %0h expected none at %0t", o_rx_data, $time);
          end else check("rx_data", 80'(o_rx_data), 80'(exp_rx.pop_front()));
        end
        prd = o_u_read; pwr = o_u_write; prxv = o_rx_valid;
      end
    end
  end

  initial begin
    bit found, drained;
    reset = 1;
    idle_inputs();
    p_txv = 0; p_rx = 0; p_ferr = 0; p_rxrdy = 100; p_txrdy = 100;
    model_reset();
    repeat (3) @(negedge clk);
    reset = 0;

    // Four pushes fill the FIFO during init; the fifth is dropped.
    force_q = '{8'h55, 8'hAA, 8'h01, 8'h7F, 8'hEE};
    run(5);
    check("tx_full_after_4", 80'(o_tx_ready), 80'd0);
    run(250);
    check("inited_after_cfg", 80'(o_inited), 80'd1);

    // Received byte held while the client is not ready.
    p_rxrdy = 0;
    rxq.push_back(8'h3C);
    rxq.push_back(8'h99);
    run(300);
    check("rx_hold_valid", 80'(o_rx_valid), 80'd1);
    check("rx_hold_data",  80'(o_rx_data), 80'h3C);
    p_rxrdy = 100;
    run(150);

    // Framing error and pending byte together: clear first.
    uferr = 1;
    rxq.push_back(8'h5A);
    run(150);
    check("ferr_first", 80'(o_ferr_cnt), 80'd1);

    // Random traffic.
    p_txv = 30; p_rx = 5; p_ferr = 2; p_rxrdy = 40; p_txrdy = 70;
    run(4000);

    // Drain everything, bounded.
    p_txv = 0; p_rx = 0; p_ferr = 0; p_rxrdy = 100; p_txrdy = 100;
    drained = 0;
    for (int i = 0; i < 2000 && !drained; i++) begin
      run(1);
      drained = (model_fifo.size() == 0) && (rxq.size() == 0) && !model_rxv && !uferr;
    end
    check("drain_done", 80'(drained), 80'd1);
    check("drain_txready", 80'(o_tx_ready), 80'd1);

    // Reset in the middle of a DATA write.
    p_txrdy = 100;
    force_q = '{8'h11, 8'h22, 8'h33};
    found = 0;
    for (int i = 0; i < 2000 && !found; i++) begin
      @(negedge clk);
      if (o_u_write && o_u_addr == 15'd0) found = 1;
      else step();
    end
    check("tx_write_seen", 80'(found), 80'd1);
    reset = 1;
    #1;
    check("midreset_strobes", 80'({o_u_read, o_u_write}), 80'd0);
    check("midreset_addr",    80'(o_u_addr), 80'd0);
    check("midreset_txready", 80'(o_tx_ready), 80'd1);
    idle_inputs();
    force_q.delete();
    model_reset();
    repeat (2) @(negedge clk);
    reset = 0;
    p_txv = 20; p_rx = 5; p_rxrdy = 60; p_txrdy = 80;
    run(400);
    check("reinited", 80'(o_inited), 80'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
